// File: rtl/wb_fetch_unit.sv
// -----------------------------------------------------------------------------
// wb_fetch_unit
//
// Instruction prefetch unit in front of a Wishbone instruction ROM. It issues
// one single-beat read cycle at a time. Each returned word is tagged with its
// byte PC and pushed into a small prefetch FIFO. The core drains that FIFO
// through a valid/ready handshake. A redirect (branch or trap) flushes the
// FIFO and restarts fetch at a new PC.
//
// Ports
//   CLK_I, RST_I         clock; asynchronous active-high reset
//   CYC_O/STB_O/WE_O     Wishbone master controls (CYC_O mirrors STB_O, WE_O=0)
//   ADR_O                ROM word address, fetch_pc[ADDRESS_WIDTH+1:2]
//   DAT_I/ACK_I          ROM read data and acknowledge
//   redirect_valid/_pc   flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   instr_valid/_data/_pc  FIFO head presented to the core
//   instr_ready          core accepts the head this cycle
// -----------------------------------------------------------------------------
module wb_fetch_unit #(
  parameter int          ADDRESS_WIDTH = 8,
  parameter int          DATA_WIDTH    = 32,
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  output logic                     CYC_O,
  output logic                     STB_O,
  output logic                     WE_O,
  output logic [ADDRESS_WIDTH-1:0] ADR_O,
  input  logic [DATA_WIDTH-1:0]    DAT_I,
  input  logic                     ACK_I,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr_data,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    TURN
  } state_t;

  state_t state, state_nxt;

  logic [31:0]            fetch_pc;
  logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
  logic [31:0]            fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count, count_after_pop;
  logic                   push, pop, has_room;
  logic                   stb;

  // A redirect voids both the pop and any coinciding ACK.
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign push = (state == REQ) && ACK_I && !redirect_valid;

  // Room is judged after this cycle's pop so a single pop on a full FIFO
  // raises STB in the very next cycle.
  assign count_after_pop = count - CNT_W'(pop);
  assign has_room        = count_after_pop < DEPTH_CNT;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_I or posedge RST_I) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of block ordering.
    if (RST_I) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    stb       = 1'b0;
    unique case (state)
      IDLE: if (has_room) state_nxt = REQ;
      REQ: begin
        stb = 1'b1;
        if (ACK_I) state_nxt = TURN;
      end
      // The ROM's registered ACK trails STB by one cycle; the trailing ACK
      // lands here and is ignored.
      TURN:    state_nxt = has_room ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) state_nxt = TURN;
  end

  assign STB_O = stb;
  assign CYC_O = stb;
  assign WE_O  = 1'b0;
  assign ADR_O = fetch_pc[ADDRESS_WIDTH+1:2];

  // ---------------------------------------------------------------------------
  // Fetch PC and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count alone defines which
  // entries are meaningful, and omitting the reset keeps this a plain RAM.
  always_ff @(posedge CLK_I) begin
    if (push) begin
      fifo_data[wr_ptr] <= DAT_I;
      fifo_pc[wr_ptr]   <= fetch_pc;
    end
  end

  assign instr_valid = (count != '0);
  assign instr_data  = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  // The low two redirect bits are forced to zero and never used.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

endmodule

// File: tb/tb_wb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_wb_fetch_unit
//
// Directed bench for wb_fetch_unit with a registered-ACK ROM model (word i
// holds 0x1000+i). A program-order model (queue of fetched PCs) is compared
// against the DUT on every falling edge; directed sequences add hand-computed
// cycle-exact expectations.
// -----------------------------------------------------------------------------
module tb_wb_fetch_unit;

  localparam int          AW       = 8;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b1;
  logic          CYC_O, STB_O, WE_O;
  logic [AW-1:0] ADR_O;
  logic [DW-1:0] DAT_I = '0;
  logic          ACK_I = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc    = '0;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [31:0]   instr_pc;
  logic          instr_ready    = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  wb_fetch_unit #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .RESET_PC     (RESET_PC)
  ) dut (
    .CLK_I         (CLK_I),
    .RST_I         (RST_I),
    .CYC_O         (CYC_O),
    .STB_O         (STB_O),
    .WE_O          (WE_O),
    .ADR_O         (ADR_O),
    .DAT_I         (DAT_I),
    .ACK_I         (ACK_I),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  always #5 CLK_I = ~CLK_I;

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return 32'h0000_1000 + {24'h0, a};
  endfunction

  function automatic logic [31:0] rom_at_pc(input logic [31:0] pc);
    return rom_word(pc[AW+1:2]);
  endfunction

  // ROM: registered ACK and data, one cycle behind STB; not reset.
  always @(posedge CLK_I) begin
    ACK_I <= STB_O;
    DAT_I <= rom_word(ADR_O);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Program-order model: PCs fetched so far but not yet consumed.
  // ---------------------------------------------------------------------------
  logic [31:0] model_q[$];
  logic [31:0] fetch_exp = RESET_PC;

  always @(negedge CLK_I) begin
    if (RST_I) begin
      model_q.delete();
      fetch_exp = RESET_PC;
      check("rst_stb", {31'd0, STB_O}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
    end else begin
      check("cyc_eq_stb", {31'd0, CYC_O}, {31'd0, STB_O});
      check("we_zero", {31'd0, WE_O}, 32'd0);
      if (STB_O) begin
        check("adr", {24'd0, ADR_O}, {24'd0, fetch_exp[AW+1:2]});
        check("stb_has_room", {31'd0, (model_q.size() < DEPTH)}, 32'd1);
      end
      check("valid", {31'd0, instr_valid}, {31'd0, (model_q.size() != 0)});
      if (instr_valid && model_q.size() != 0) begin
        check("head_pc", instr_pc, model_q[0]);
        check("head_data", instr_data, rom_at_pc(model_q[0]));
      end
      if (redirect_valid) begin
        model_q.delete();
        fetch_exp = {redirect_pc[31:2], 2'b00};
      end else begin
        if (instr_valid && instr_ready && model_q.size() != 0) void'(model_q.pop_front());
        if (STB_O && ACK_I) begin
          model_q.push_back(fetch_exp);
          fetch_exp = fetch_exp + 32'd4;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // Leaves the bench in cycle 0: reset just released, next edge is IDLE->REQ.
  task automatic do_reset();
    RST_I          = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) tick();
    RST_I = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int stb_hits;

    // --- Streaming from reset, one word every 3 cycles ---
    instr_ready = 1'b1;
    do_reset();
    check("t1_c0_stb", {31'd0, STB_O}, 32'd0);
    check("t1_c0_adr", {24'd0, ADR_O}, 32'd0);
    tick();
    check("t1_c1_stb", {31'd0, STB_O}, 32'd1);
    check("t1_c1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("t1_c2_ack", {31'd0, ACK_I}, 32'd1);
    check("t1_c2_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("t1_valid", {31'd0, instr_valid}, 32'd1);
      check("t1_pc", instr_pc, 32'(4 * i));
      check("t1_data", instr_data, 32'h1000 + 32'(i));
      tick();
      check("t1_gap1", {31'd0, instr_valid}, 32'd0);
      tick();
      check("t1_gap2", {31'd0, instr_valid}, 32'd0);
      tick();
    end

    // --- Full FIFO parks in IDLE; one pop restarts fetch next cycle ---
    instr_ready = 1'b0;
    do_reset();
    stb_hits = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k >= 12 && STB_O) stb_hits++;
    end
    check("t2_parked_stb_hits", 32'(stb_hits), 32'd0);
    check("t2_head_valid", {31'd0, instr_valid}, 32'd1);
    check("t2_head_pc", instr_pc, 32'h0);
    check("t2_adr_next", {24'd0, ADR_O}, 32'd4);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("t2_refetch_stb", {31'd0, STB_O}, 32'd1);
    check("t2_refetch_adr", {24'd0, ADR_O}, 32'd4);
    check("t2_head_pc_after_pop", instr_pc, 32'h4);
    check("t2_head_data_after_pop", instr_data, 32'h1001);
    instr_ready = 1'b1;
    repeat (20) tick();

    // --- Redirect coinciding with the ACK for pc 0x8 ---
    instr_ready = 1'b1;
    do_reset();
    repeat (8) tick();
    check("t3_ack_pc8", {31'd0, ACK_I}, 32'd1);
    check("t3_adr_pc8", {24'd0, ADR_O}, 32'd2);
    redirect_to(32'h40);
    check("t3_n1_valid", {31'd0, instr_valid}, 32'd0);
    check("t3_n1_stb", {31'd0, STB_O}, 32'd0);
    tick();
    check("t3_n2_stb", {31'd0, STB_O}, 32'd1);
    check("t3_n2_adr", {24'd0, ADR_O}, 32'h10);
    tick();
    check("t3_n3_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("t3_n4_valid", {31'd0, instr_valid}, 32'd1);
    check("t3_n4_pc", instr_pc, 32'h40);
    check("t3_n4_data", instr_data, 32'h1010);
    repeat (10) tick();

    // --- Redirect on a full FIFO with a simultaneous pop; unaligned target ---
    instr_ready = 1'b0;
    do_reset();
    repeat (20) tick();
    check("t4_full_head", instr_pc, 32'h0);
    check("t4_full_stb", {31'd0, STB_O}, 32'd0);
    instr_ready = 1'b1;
    redirect_to(32'h43);
    instr_ready = 1'b0;
    check("t4_n1_valid", {31'd0, instr_valid}, 32'd0);
    check("t4_n1_stb", {31'd0, STB_O}, 32'd0);
    tick();
    check("t4_n2_stb", {31'd0, STB_O}, 32'd1);
    check("t4_n2_adr", {24'd0, ADR_O}, 32'h10);
    repeat (2) tick();
    check("t4_n4_valid", {31'd0, instr_valid}, 32'd1);
    check("t4_n4_pc", instr_pc, 32'h40);
    check("t4_n4_data", instr_data, 32'h1010);
    instr_ready = 1'b1;
    repeat (6) tick();

    // --- Asynchronous reset in the middle of a request ---
    instr_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    check("t5_pre_stb", {31'd0, STB_O}, 32'd1);
    check("t5_pre_ack", {31'd0, ACK_I}, 32'd1);
    check("t5_pre_valid", {31'd0, instr_valid}, 32'd1);
    check("t5_pre_adr", {24'd0, ADR_O}, 32'd1);
    #1 RST_I = 1'b1;
    #1;
    check("t5_async_stb", {31'd0, STB_O}, 32'd0);
    check("t5_async_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_async_adr", {24'd0, ADR_O}, {24'd0, RESET_PC[AW+1:2]});
    #4 RST_I = 1'b0;
    check("t5_stray_ack", {31'd0, ACK_I}, 32'd1);
    tick();
    check("t5_c1_stb", {31'd0, STB_O}, 32'd1);
    check("t5_c1_adr", {24'd0, ADR_O}, 32'd0);
    check("t5_c1_valid", {31'd0, instr_valid}, 32'd0);
    repeat (2) tick();
    check("t5_c3_valid", {31'd0, instr_valid}, 32'd1);
    check("t5_c3_pc", instr_pc, RESET_PC);
    check("t5_c3_data", instr_data, 32'h1000);
    instr_ready = 1'b1;
    repeat (6) tick();

    // --- ROM address aliasing past ADDRESS_WIDTH ---
    instr_ready = 1'b1;
    redirect_to(32'h3F8);
    tick();
    check("t6_adr_fe", {24'd0, ADR_O}, 32'hFE);
    repeat (2) tick();
    check("t6_pc_3f8", instr_pc, 32'h3F8);
    check("t6_data_3f8", instr_data, 32'h10FE);
    tick();
    check("t6_adr_ff", {24'd0, ADR_O}, 32'hFF);
    repeat (2) tick();
    check("t6_pc_3fc", instr_pc, 32'h3FC);
    tick();
    check("t6_adr_00", {24'd0, ADR_O}, 32'h00);
    repeat (2) tick();
    check("t6_pc_400", instr_pc, 32'h400);
    check("t6_data_400", instr_data, 32'h1000);

    // --- 32-bit PC wrap ---
    redirect_to(32'hFFFF_FFFC);
    repeat (3) tick();
    check("t7_pc_top", instr_pc, 32'hFFFF_FFFC);
    check("t7_data_top", instr_data, 32'h10FF);
    repeat (3) tick();
    check("t7_pc_wrap", instr_pc, 32'h0);
    check("t7_data_wrap", instr_data, 32'h1000);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_fetch_unit.md
# wb_fetch_unit

Instruction prefetch unit sitting directly upstream of the Wishbone instruction ROM. It issues single-beat Wishbone read cycles to the ROM and pushes each returned word, tagged with its PC, into a small prefetch FIFO. The core drains the FIFO through a valid/ready interface and can redirect fetch, for a branch or trap, at any time.

## Interface
- ADDRESS_WIDTH, 8, word-address width of ADR_O; matches the ROM's ADDRESS_WIDTH
- DATA_WIDTH, 32, instruction word width
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, byte PC fetched first after reset
- CLK_I  in  1  single clock; all state updates on its rising edge
- RST_I  in  1  reset, asynchronous, active-high
- CYC_O  out  1  Wishbone cycle; always equal to STB_O
- STB_O  out  1  Wishbone strobe
- WE_O  out  1  tied 0
- ADR_O  out  ADDRESS_WIDTH  word address, pc[ADDRESS_WIDTH+1:2]
- DAT_I  in  DATA_WIDTH  read data from ROM
- ACK_I  in  1  ROM acknowledge
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new byte PC; bits [1:0] ignored and treated as 0
- instr_valid  out  1  FIFO head valid (FIFO not empty)
- instr_data  out  DATA_WIDTH  FIFO head instruction
- instr_pc  out  32  FIFO head byte PC
- instr_ready  in  1  core accepts head; pop when instr_valid && instr_ready

## Operation
- State machine:
  - IDLE: STB_O=0. Move to REQ when count<FIFO_DEPTH.
  - REQ: STB_O=1 with ADR_O from fetch_pc. Hold until ACK_I=1. On ACK, push {DAT_I, fetch_pc}, add 4 to fetch_pc, and go to TURN.
  - TURN: STB_O=0 for exactly one cycle. ACK_I is ignored in this state, because the ROM's registered ACK trails STB by one cycle. Then go to REQ if count<FIFO_DEPTH (count taken after this cycle's pop), else IDLE.
- Only one request is ever outstanding. A request starts only when the FIFO has a free slot, so an ACK never meets a full FIFO.
- Push and pop in the same cycle are allowed; count is unchanged.
- fetch_pc is 32 bits and wraps modulo 2^32. ADR_O truncates the address to ADDRESS_WIDTH bits, so it aliases within the ROM.
- Redirect has priority over everything else in that cycle:
  - The FIFO is flushed (count=0), and any pop in the same cycle is void.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - state ← TURN, so STB_O=0 next cycle and any in-flight ACK is discarded.
  - An ACK coinciding with redirect is dropped; its data is never pushed.
- instr_data and instr_pc are driven combinationally from the FIFO head registers. They are don't-care when instr_valid=0.
- WE_O=0 always. DAT_O toward the ROM is not driven by this block.

## Timing
- Reset values: STB_O=0, CYC_O=0, WE_O=0, ADR_O=RESET_PC[ADDRESS_WIDTH+1:2], instr_valid=0, state=IDLE, fetch_pc=RESET_PC, FIFO empty.
- Reset asserted mid-transaction drops STB_O immediately (asynchronous). A later ROM ACK arrives while in IDLE and is ignored.
- First edge after reset release: IDLE→REQ, so STB_O is high in cycle 1. The ROM ACKs in cycle 2 and the push happens at the end of cycle 2. instr_valid=1 in cycle 3.
- Steady state with the ROM's 1-cycle ACK: 3 cycles per word (REQ, REQ+ACK, TURN). A slower slave stretches REQ.
- Redirect asserted in cycle n:
  - instr_valid=0 in cycle n+1.
  - STB_O=0 in n+1 (TURN) and STB_O=1 at redirect_pc in n+2.
  - The first redirected instruction is valid in n+4.
- Full FIFO: the unit parks in IDLE with STB_O=0. The first pop re-enables fetch, with STB_O=1 the cycle after the pop.

## Test plan
- Reset, ROM preloaded with word i = 0x1000+i, instr_ready=1 → instr_valid first in cycle 3 with pc 0x0 and data 0x1000; then pc 0x4, 0x8, … one every 3 cycles, no gaps or duplicates.
- instr_ready=0 for 30 cycles, FIFO_DEPTH=4 → exactly 4 entries (pc 0x0 to 0xC); STB_O stays 0 after the 4th push. Pop one → STB_O=1 the next cycle at ADR_O=4.
- Redirect to 0x40 on the cycle ACK_I=1 for pc 0x8 → word at 0x8 is never presented; FIFO empties; the next instruction out has pc 0x40 and data 0x1010.
- Redirect with FIFO full and instr_ready=1 in the same cycle → no pop is counted; the next valid has pc=redirect_pc. Redirect with redirect_pc=0x43 → fetch at 0x40.
- RST_I pulsed asynchronously mid-REQ → STB_O and instr_valid go to 0 without waiting for a clock edge. After release, fetch restarts at RESET_PC and the stray ROM ACK is ignored.
- ADDRESS_WIDTH=8, start at 0x3F8 → ADR_O 0xFE, 0xFF, then 0x00 (pc 0x400). instr_pc keeps its full 32-bit value.
